// File: rtl/vision_fb_scheduler_if.sv
// Camera/display DMA handshake bundle for vision_fb_scheduler.
// The master modport is the DMA side and the slave modport is the scheduler side.
interface vision_fb_scheduler_if;
  logic        cam_req;
  logic        cam_ack;
  logic [31:0] cam_base_addr;
  logic        cam_done;
  logic        disp_req;
  logic        disp_ack;
  logic [31:0] disp_base_addr;
  logic        disp_new;
  logic        disp_done;

  modport master (
    output cam_req, cam_done, disp_req, disp_done,
    input  cam_ack, cam_base_addr, disp_ack, disp_base_addr, disp_new
  );

  modport slave (
    input  cam_req, cam_done, disp_req, disp_done,
    output cam_ack, cam_base_addr, disp_ack, disp_base_addr, disp_new
  );
endinterface

// File: rtl/vision_fb_scheduler.sv
// Triple-buffer frame scheduler between a camera writer and a display reader.
// Defining FB_SCHED_FREEZE_EN adds the i_freeze input; while it is high, commits are discarded.
module vision_fb_scheduler #(
  parameter logic [31:0] BUF_BASE   = 32'h0100_0000,
  parameter logic [31:0] BUF_STRIDE = 32'h0080_0000
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_enable,
`ifdef FB_SCHED_FREEZE_EN
  input  logic                        i_freeze,
`endif
  vision_fb_scheduler_if.slave        fb,
  output logic [15:0]                 drop_cnt,
  output logic [15:0]                 repeat_cnt,
  output logic                        seq_err
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} side_state_e;

  side_state_e cam_state_q, cam_state_d;
  side_state_e disp_state_q, disp_state_d;
  logic [1:0]  w_idx_q, w_idx_d, r_idx_q, r_idx_d, d_idx_q, d_idx_d;
  logic        r_valid_q, r_valid_d, d_valid_q, d_valid_d;
  logic        cam_ack_q, cam_ack_d, disp_ack_q, disp_ack_d;
  logic        disp_new_q, disp_new_d;
  logic [31:0] cam_addr_q, cam_addr_d, disp_addr_q, disp_addr_d;
  logic [15:0] drop_q, drop_d, repeat_q, repeat_d;
  logic        seq_err_q, seq_err_d;
  logic        freeze, cam_grant, commit, disp_grant;

`ifdef FB_SCHED_FREEZE_EN
  assign freeze = i_freeze;
`else
  assign freeze = 1'b0;
`endif

  function automatic logic [31:0] addr_of(input logic [1:0] idx);
    logic [31:0] a;
    case (idx)
      2'd0:    a = BUF_BASE;
      2'd1:    a = BUF_BASE + BUF_STRIDE;
      default: a = BUF_BASE + {BUF_STRIDE[30:0], 1'b0};
    endcase
    return a;
  endfunction

  assign cam_grant  = (cam_state_q == IDLE) && fb.cam_req && i_enable;
  assign commit     = (cam_state_q == ACTIVE) && fb.cam_done;
  assign disp_grant = (disp_state_q == IDLE) && fb.disp_req && i_enable;

  always_comb begin
    cam_state_d  = cam_state_q;
    disp_state_d = disp_state_q;
    w_idx_d      = w_idx_q;
    r_idx_d      = r_idx_q;
    d_idx_d      = d_idx_q;
    r_valid_d    = r_valid_q;
    d_valid_d    = d_valid_q;
    cam_ack_d    = 1'b0;
    disp_ack_d   = 1'b0;
    disp_new_d   = disp_new_q;
    cam_addr_d   = cam_addr_q;
    disp_addr_d  = disp_addr_q;
    drop_d       = drop_q;
    repeat_d     = repeat_q;
    seq_err_d    = seq_err_q;

    if (cam_grant) begin
      cam_state_d = ACTIVE;
      cam_ack_d   = 1'b1;
      cam_addr_d  = addr_of(w_idx_q);
    end

    // The commit is resolved first so a same-cycle display grant sees the fresh frame.
    if (commit) begin
      cam_state_d = IDLE;
      if (!freeze) begin
        w_idx_d   = r_idx_q;
        r_idx_d   = w_idx_q;
        r_valid_d = 1'b1;
        if (r_valid_q && (drop_q != 16'hFFFF)) begin
          drop_d = drop_q + 16'd1;
        end
      end
    end

    if (disp_grant) begin
      disp_state_d = ACTIVE;
      disp_ack_d   = 1'b1;
      if (r_valid_d && !freeze) begin
        d_idx_d    = r_idx_d;
        r_idx_d    = d_idx_q;
        r_valid_d  = 1'b0;
        d_valid_d  = 1'b1;
        disp_new_d = 1'b1;
      end else begin
        disp_new_d = 1'b0;
        if (d_valid_q && (repeat_q != 16'hFFFF)) begin
          repeat_d = repeat_q + 16'd1;
        end
      end
      disp_addr_d = addr_of(d_idx_d);
    end

    if ((disp_state_q == ACTIVE) && fb.disp_done) begin
      disp_state_d = IDLE;
    end

    if ((fb.cam_done && (cam_state_q != ACTIVE)) ||
        (fb.disp_done && (disp_state_q != ACTIVE))) begin
      seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cam_state_q  <= IDLE;
      disp_state_q <= IDLE;
      d_idx_q      <= 2'd0;
      w_idx_q      <= 2'd1;
      r_idx_q      <= 2'd2;
      r_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      cam_ack_q    <= 1'b0;
      disp_ack_q   <= 1'b0;
      disp_new_q   <= 1'b0;
      cam_addr_q   <= BUF_BASE + BUF_STRIDE;
      disp_addr_q  <= BUF_BASE;
      drop_q       <= 16'd0;
      repeat_q     <= 16'd0;
      seq_err_q    <= 1'b0;
    end else begin
      cam_state_q  <= cam_state_d;
      disp_state_q <= disp_state_d;
      d_idx_q      <= d_idx_d;
      w_idx_q      <= w_idx_d;
      r_idx_q      <= r_idx_d;
      r_valid_q    <= r_valid_d;
      d_valid_q    <= d_valid_d;
      cam_ack_q    <= cam_ack_d;
      disp_ack_q   <= disp_ack_d;
      disp_new_q   <= disp_new_d;
      cam_addr_q   <= cam_addr_d;
      disp_addr_q  <= disp_addr_d;
      drop_q       <= drop_d;
      repeat_q     <= repeat_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign fb.cam_ack        = cam_ack_q;
  assign fb.cam_base_addr  = cam_addr_q;
  assign fb.disp_ack       = disp_ack_q;
  assign fb.disp_base_addr = disp_addr_q;
  assign fb.disp_new       = disp_new_q;
  assign drop_cnt          = drop_q;
  assign repeat_cnt        = repeat_q;
  assign seq_err           = seq_err_q;

endmodule

// File: doc/vision_fb_scheduler.md
VISION_FB_SCHEDULER -- requirements
Module: vision_fb_scheduler

Interface
REQ-001 Parameter BUF_BASE, default 32'h0100_0000: byte address of frame buffer 0.
REQ-002 Parameter BUF_STRIDE, default 32'h0080_0000: byte distance between consecutive frame buffers.
REQ-003 Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  peripheral clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_enable  in  1  level; permits new grants.
- cam_req  in  1  level; camera DMA requests a write buffer.
- cam_ack  out  1  one-cycle grant pulse.
- cam_base_addr  out  32  write buffer address, valid from cam_ack until next grant.
- cam_done  in  1  pulse; camera frame fully written.
- disp_req  in  1  level; display DMA requests a read buffer.
- disp_ack  out  1  one-cycle grant pulse.
- disp_base_addr  out  32  read buffer address, valid from disp_ack until next grant.
- disp_new  out  1  registered with disp_ack; 1 = fresh frame, 0 = repeat or none.
- disp_done  in  1  pulse; display frame fully read.
- drop_cnt  out  16  saturating count of completed frames overwritten before display.
- repeat_cnt  out  16  saturating count of display grants repeating a frame.
- seq_err  out  1  sticky; done received while its side not ACTIVE.

Function
REQ-004 Three buffers, indices 0..2; registers w_idx (write), r_idx (latest complete), d_idx (display), flags r_valid, d_valid; w_idx, r_idx, d_idx SHALL always be pairwise distinct.
REQ-005 Address = BUF_BASE + idx*BUF_STRIDE, 32-bit, modulo 2^32 wrap.
REQ-006 Camera FSM states IDLE, ACTIVE; IDLE with cam_req=1 and i_enable=1 -> cam_ack=1 next cycle, cam_base_addr from w_idx, state ACTIVE.
REQ-007 ACTIVE with cam_done=1 (commit): swap w_idx and r_idx; r_valid<=1; drop_cnt+1 if r_valid was 1; state IDLE.
REQ-008 Display FSM states IDLE, ACTIVE; IDLE with disp_req=1 and i_enable=1 -> disp_ack=1 next cycle, state ACTIVE.
REQ-009 Display grant with r_valid=1: swap d_idx and r_idx, r_valid<=0, d_valid<=1, disp_new=1; with r_valid=0 and d_valid=1: keep d_idx, disp_new=0, repeat_cnt+1; with both 0: address of d_idx, disp_new=0, no count.
REQ-010 Display ACTIVE with disp_done=1 -> IDLE.
REQ-011 Commit and display grant in same cycle: commit applied first; display receives just-committed buffer (new d = old w, new r = old d, new w = old r, r_valid=0).
REQ-012 cam_done outside camera ACTIVE, or disp_done outside display ACTIVE: ignored, seq_err<=1 (cleared only by reset).
REQ-013 i_enable=0 blocks only new grants; ACTIVE frames complete normally.
REQ-014 Requests still high on returning to IDLE are regranted no earlier than one cycle after the done pulse; each grant is one cycle.
REQ-015 Counters saturate at 16'hFFFF.

Reset
REQ-016 rstn low asynchronously forces: both FSMs IDLE, d_idx=0, w_idx=1, r_idx=2, r_valid=0, d_valid=0, counters 0, seq_err=0, cam_ack=0, disp_ack=0, disp_new=0, cam_base_addr=BUF_BASE+BUF_STRIDE, disp_base_addr=BUF_BASE.
REQ-017 Reset mid-frame aborts both sides; first grant after release follows REQ-016 values.

Configuration
REQ-018 Macro FB_SCHED_FREEZE_EN defined: adds input i_freeze (1 bit); while 1, commits return camera FSM to IDLE without swap, r_valid and drop_cnt unchanged, display repeats current frame.
REQ-019 FB_SCHED_FREEZE_EN undefined: no i_freeze port; behaviour equals i_freeze=0.

Verification
REQ-020 Reset release, cam_req=1 -> cam_ack after 1 cycle, cam_base_addr=32'h0180_0000; cam_done -> r_idx=1; disp_req -> disp_base_addr=32'h0180_0000, disp_new=1.
REQ-021 Three cam frames committed, no disp_req -> drop_cnt=2; next disp grant returns last committed buffer, disp_new=1.
REQ-022 Two disp grants, no commit in between -> second disp_new=0, repeat_cnt=1, same disp_base_addr.
REQ-023 cam_done and disp grant same cycle after reset -> disp_base_addr=32'h0180_0000, next cam grant 32'h0200_0000, indices distinct.
REQ-024 cam_done while camera IDLE -> seq_err=1, indices unchanged; rstn pulse mid-frame -> all REQ-016 values.
REQ-025 FB_SCHED_FREEZE_EN, i_freeze=1 over two commits -> drop_cnt=0, display repeats, cam_base_addr unchanged.
